// File: rtl/alu_pkg.sv
// Shared operation encodings and helpers for the ALU, its control decoder and the datapath.
// All consumers import this package so the OP_* values live in exactly one place.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // Signed compare done directly, never via the sign of a-b, so overflow cannot flip it.
   function automatic logic signed_lt(input logic [ALU_WIDTH-1:0] x,
                                      input logic [ALU_WIDTH-1:0] y);
      return $signed(x) < $signed(y);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: selects the result for the current op and flags a zero result.
// Unused or unknown op codes fall to the default arm and produce zero.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic [4:0]       shamt,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SLL:  result = a << shamt;
         OP_SUB:  result = a - b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, signed_lt(a, b)};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: one cycle of latency, result and zero flag captured on the same edge.
// Reset forces a zero result, so the flag reads 1 while rst_n is low.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] out,
   output logic             zout,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic [4:0]       shamt
);

   logic [WIDTH-1:0] out_next;
   logic             zout_next;
   logic [WIDTH-1:0] out_reg;
   logic             zout_reg;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (a),
      .b      (b),
      .op     (op),
      .shamt  (shamt),
      .result (out_next),
      .zero   (zout_next)
   );

   // Flag is registered alongside the result so the two never skew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg  <= '0;
         zout_reg <= 1'b1;
      end else begin
         out_reg  <= out_next;
         zout_reg <= zout_next;
      end
   end

   assign out  = out_reg;
   assign zout = zout_reg;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations are queued when inputs are driven and
// popped one edge later when the registered result appears.
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] out;
   logic        zout;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic [4:0]  shamt;

   typedef struct {
      logic [31:0] res;
      logic        z;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   always #5 clk = ~clk;

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .out   (out),
      .zout  (zout),
      .a     (a),
      .b     (b),
      .op    (op),
      .shamt (shamt)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp)
         checks_passed++;
      else
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Independent reference: SLT decided from sign bits, SLL via a wide shift.
   function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] o, input logic [4:0] sh);
      logic [63:0] wide;
      case (o)
         3'b000: return x & y;
         3'b001: return x | y;
         3'b010: return x + y;
         3'b011: begin
            wide = {32'd0, x} << sh;
            return wide[31:0];
         end
         3'b110: return x + ~y + 32'd1;
         3'b111: return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, (x < y)};
         default: return 32'd0;
      endcase
   endfunction

   task automatic apply(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [2:0] top, input logic [4:0] tsh, input logic [31:0] eres);
      exp_t e;
      @(negedge clk);
      a = ta; b = tb_v; op = top; shamt = tsh;
      sb_q.push_back('{res: eres, z: (eres == 32'd0), tag: tag});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks_total++;
         $display("FAIL %s: scoreboard empty, got out=%h", tag, out);
      end else begin
         e = sb_q.pop_front();
         check_val({e.tag, ".out"}, out, e.res);
         check_val({e.tag, ".zout"}, {31'd0, zout}, {31'd0, e.z});
      end
      $display("txn %-10s op=%b a=%h b=%h sh=%0d -> out=%h zout=%b", tag, top, ta, tb_v, tsh, out, zout);
   endtask

   initial begin
      logic [31:0] ra, rb, er;
      logic [2:0]  ro;
      logic [4:0]  rs;

      rst_n = 1'b0;
      a = 32'd5; b = 32'd5; op = OP_ADD; shamt = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset.out", out, 32'd0);
      check_val("reset.zout", {31'd0, zout}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      apply("add",      32'd1,        32'd28,       OP_ADD, 5'd0,  32'd29);
      apply("sub_neg",  32'd1,        32'd28,       OP_SUB, 5'd0,  32'hFFFFFFE5);
      apply("sub_zero", 32'd32,       32'd32,       OP_SUB, 5'd0,  32'd0);
      apply("add_wrap", 32'hFFFFFFFF, 32'd1,        OP_ADD, 5'd0,  32'd0);
      apply("or",       32'h72,       32'hA1,       OP_OR,  5'd0,  32'hF3);
      apply("and",      32'h72,       32'hA1,       OP_AND, 5'd0,  32'h20);
      apply("slt_6_2",  32'd6,        32'd2,        OP_SLT, 5'd0,  32'd0);
      apply("slt_23_34",32'd23,       32'd34,       OP_SLT, 5'd0,  32'd1);
      apply("slt_m1_1", 32'hFFFFFFFF, 32'd1,        OP_SLT, 5'd0,  32'd1);
      apply("slt_max",  32'h7FFFFFFF, 32'h80000000, OP_SLT, 5'd0,  32'd0);
      apply("slt_min0", 32'h80000000, 32'd0,        OP_SLT, 5'd0,  32'd1);
      apply("sll_3",    32'd23,       32'd34,       OP_SLL, 5'd3,  32'd184);
      apply("sll_0",    32'd23,       32'd34,       OP_SLL, 5'd0,  32'd23);
      apply("unused4",  32'd9,        32'd7,        3'b100, 5'd1,  32'd0);
      apply("unused5",  32'd9,        32'd7,        3'b101, 5'd1,  32'd0);
      apply("sll_31",   32'd1,        32'd0,        OP_SLL, 5'd31, 32'h80000000);

      // Mid-run asynchronous reset: out must clear without any clock edge.
      @(negedge clk);
      a = 32'h1234; b = 32'h1; op = OP_ADD;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst.out", out, 32'd0);
      check_val("async_rst.zout", {31'd0, zout}, 32'd1);
      @(posedge clk);
      #1;
      check_val("hold_rst.out", out, 32'd0);
      check_val("hold_rst.zout", {31'd0, zout}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back random ops, a new one every cycle.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : $urandom;
         ro = 3'($urandom_range(0, 7));
         rs = 5'($urandom_range(0, 31));
         er = ref_model(ra, rb, ro, rs);
         apply($sformatf("rnd%0d", i), ra, rb, ro, rs, er);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
